// File: rtl/nibble_serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_if
// Description : Operand and result valid/ready bundle for nibble_serial_adder.
//               The slave modport is the adder's view. The master modport
//               is the view of the logic that drives operands and takes
//               results.
//               The in_sub signal exists only when NSA_SUB_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
`ifdef NSA_SUB_EN
    logic             in_sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;
    logic             out_ovf;

    modport slave (
`ifdef NSA_SUB_EN
        input  in_sub,
`endif
        input  in_valid,
        input  in_a,
        input  in_b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_ovf
    );

    modport master (
`ifdef NSA_SUB_EN
        output in_sub,
`endif
        output in_valid,
        output in_a,
        output in_b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_ovf
    );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder
// Description : WIDTH-bit adder that uses one 4-bit carry-lookahead slice.
//               It processes one nibble per clock, LSB first, and passes the
//               carry between nibbles through a register.
//               Operands enter and the {carry, sum} result leaves over
//               valid/ready handshakes. Latency is WIDTH/4 cycles.
//               Optional feature macro: NSA_SUB_EN. It adds the in_sub input,
//               and in_sub = 1 computes A - B.
// Revision    : 1.0  initial release
// ============================================================================
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    nibble_serial_adder_if.slave  bus
);
    localparam int c_N    = WIDTH / 4;
    localparam int c_IDXW = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_IDXW-1:0] c_LAST = c_IDXW'(c_N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;        // B' : already inverted for subtraction
    logic [c_IDXW-1:0] r_idx;
    logic              r_c;
    logic [WIDTH:0]    r_sum;
    logic              r_ovf;

    logic              w_sub;
    logic              w_last;
    logic [3:0]        w_a_nib;
    logic [3:0]        w_b_nib;
    logic [3:0]        w_g;
    logic [3:0]        w_p;
    logic [4:0]        w_c;
    logic [3:0]        w_s;

`ifdef NSA_SUB_EN
    assign w_sub = bus.in_sub;
`else
    assign w_sub = 1'b0;
`endif

    assign w_last = (r_idx == c_LAST);

    // Select the operand nibble that the current RUN cycle works on.
    always_comb begin
        w_a_nib = 4'd0;
        w_b_nib = 4'd0;
        for (int n = 0; n < c_N; n++) begin
            if (r_idx == c_IDXW'(n)) begin
                w_a_nib = r_a[4*n +: 4];
                w_b_nib = r_b[4*n +: 4];
            end
        end
    end

    // 4-bit carry-lookahead slice. Every carry is built directly from g, p and c0.
    assign w_g    = w_a_nib & w_b_nib;
    assign w_p    = w_a_nib | w_b_nib;
    assign w_c[0] = r_c;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_s    = w_a_nib ^ w_b_nib ^ w_c[3:0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs. Both handshake outputs are decoded from state only.
    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: capture operands on accept, then build the result one nibble per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_idx <= '0;
            r_c   <= 1'b0;
            r_sum <= '0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a   <= bus.in_a;
                        r_b   <= w_sub ? ~bus.in_b : bus.in_b;
                        r_c   <= w_sub;
                        r_idx <= '0;
                    end
                end
                ST_RUN: begin
                    for (int n = 0; n < c_N; n++) begin
                        if (r_idx == c_IDXW'(n)) begin
                            r_sum[4*n +: 4] <= w_s;
                        end
                    end
                    r_c <= w_c[4];
                    if (w_last) begin
                        r_idx        <= '0;
                        r_sum[WIDTH] <= w_c[4];
                        r_ovf        <= (r_a[WIDTH-1] == r_b[WIDTH-1])
                                      & (w_s[3] != r_a[WIDTH-1]);
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.out_sum = r_sum;
    assign bus.out_ovf = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_adder
// Description : Self-checking bench for nibble_serial_adder with WIDTH=16.
//               It covers reset state, latency, stalls, ignored in_valid,
//               mid-run reset, and random operands compared with a model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_nibble_serial_adder;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nibble_serial_adder_if #(.WIDTH(W)) bus_if ();
    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int nvec = 0;
    int nmis = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        int          hold;
        logic [16:0] sum;
        logic        ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Reference: signed and unsigned results from plain integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic sub);
        int          sa;
        int          sb;
        int          r;
        logic [16:0] s;
        logic        ovf;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            s[15:0] = a - b;
            s[16]   = (a >= b);
            r       = sa - sb;
        end else begin
            s = {1'b0, a} + {1'b0, b};
            r = sa + sb;
        end
        ovf = (r > 32767) || (r < -32768);
        return {ovf, s};
    endfunction

    task automatic drive_sub(input logic sub);
`ifdef NSA_SUB_EN
        bus_if.in_sub = sub;
`else
        if (sub) $display("note: subtraction requested without NSA_SUB_EN");
`endif
    endtask

    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input int hold,
                          input logic [16:0] exp_sum, input logic exp_ovf);
        int to;
        int lat;
        @(negedge clk);
        to = 0;
        while (!bus_if.in_ready && to < 20) begin
            @(negedge clk);
            to++;
        end
        chk({name, " in_ready idle"}, 32'(bus_if.in_ready), 32'd1);
        bus_if.in_a      = a;
        bus_if.in_b      = b;
        drive_sub(sub);
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        lat = 0;
        while (!bus_if.out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({name, " latency"}, 32'(lat), 32'd4);
        chk({name, " sum"}, 32'(bus_if.out_sum), 32'(exp_sum));
        chk({name, " ovf"}, 32'(bus_if.out_ovf), 32'(exp_ovf));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({name, " hold out_valid"}, 32'(bus_if.out_valid), 32'd1);
            chk({name, " hold in_ready"}, 32'(bus_if.in_ready), 32'd0);
            chk({name, " hold sum"}, 32'(bus_if.out_sum), 32'(exp_sum));
        end
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({name, " in_ready after consume"}, 32'(bus_if.in_ready), 32'd1);
        chk({name, " out_valid after consume"}, 32'(bus_if.out_valid), 32'd0);
        bus_if.out_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] m;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;
        int          to;

        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.in_a      = '0;
        bus_if.in_b      = '0;
        bus_if.out_ready = 1'b0;
        drive_sub(1'b0);

        tbl.push_back('{16'hFFFF, 16'h0001, 1'b0, 0, 17'h10000, 1'b0});
        tbl.push_back('{16'h7FFF, 16'h0001, 1'b0, 0, 17'h08000, 1'b1});
        tbl.push_back('{16'h1234, 16'h4321, 1'b0, 5, 17'h05555, 1'b0});
        tbl.push_back('{16'h8000, 16'h8000, 1'b0, 1, 17'h10000, 1'b1});
        tbl.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 0, 17'h1FFFE, 1'b0});
        tbl.push_back('{16'h0000, 16'h0000, 1'b0, 2, 17'h00000, 1'b0});
`ifdef NSA_SUB_EN
        tbl.push_back('{16'h0005, 16'h0007, 1'b1, 0, 17'h0FFFE, 1'b0});
        tbl.push_back('{16'h8000, 16'h0001, 1'b1, 0, 17'h17FFF, 1'b1});
        tbl.push_back('{16'h0007, 16'h0007, 1'b1, 1, 17'h10000, 1'b0});
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", 32'(bus_if.in_ready), 32'd1);
        chk("reset out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("reset out_sum", 32'(bus_if.out_sum), 32'd0);
        chk("reset out_ovf", 32'(bus_if.out_ovf), 32'd0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < tbl.size(); i++) begin
            run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].hold,
                   tbl[i].sum, tbl[i].ovf);
        end

        // in_valid pulsed during RUN must be ignored
        @(negedge clk);
        bus_if.in_a      = 16'h0001;
        bus_if.in_b      = 16'h0002;
        drive_sub(1'b0);
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.in_a = 16'hAAAA;
        bus_if.in_b = 16'hAAAA;
        chk("spur in_ready in RUN", 32'(bus_if.in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        to = 0;
        while (!bus_if.out_valid && to < 50) begin
            @(posedge clk);
            to++;
            @(negedge clk);
        end
        chk("spur out_valid", 32'(bus_if.out_valid), 32'd1);
        chk("spur sum", 32'(bus_if.out_sum), 32'h00003);
        @(posedge clk);
        @(negedge clk);
        chk("spur in_ready after", 32'(bus_if.in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("spur no phantom op", 32'(bus_if.out_valid), 32'd0);
        end
        chk("spur sum held in idle", 32'(bus_if.out_sum), 32'h00003);
        bus_if.out_ready = 1'b0;

        // Reset during the second RUN cycle
        @(negedge clk);
        bus_if.in_a     = 16'hFFFF;
        bus_if.in_b     = 16'hFFFF;
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst in_ready", 32'(bus_if.in_ready), 32'd1);
        chk("midrst out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("midrst out_sum", 32'(bus_if.out_sum), 32'd0);
        chk("midrst out_ovf", 32'(bus_if.out_ovf), 32'd0);
        run_op("after reset", 16'h0010, 16'h0020, 1'b0, 0, 17'h00030, 1'b0);

        // Random operands against the reference model
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
`ifdef NSA_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            m = model(ra, rb, rs);
            run_op($sformatf("rand%0d", i), ra, rb, rs, int'($urandom_range(0, 2)),
                   m[16:0], m[17]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
`default_nettype wire
